// File: rtl/led_pkg.sv
// Shared constants, state type and divisor helper for the LED blink monitor.
package led_pkg;

  localparam logic [27:0] CNT_1S  = 28'h5F5E100;
  localparam logic [4:0]  DIV_MAX = 5'h14;

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED, STUCK} mon_state_t;

  // Terminal count for a divisor; out-of-range divisors fall back to the base count.
  function automatic logic [27:0] cnt_max_f(input logic [27:0] base, input logic [4:0] div);
    if (div == 5'd0 || div > DIV_MAX) return base;
    return base / {23'd0, div};
  endfunction

endpackage

// File: rtl/led_blink_mon_if.sv
// Configuration and status bundle between the blink monitor and its host.
interface led_blink_mon_if;
  logic        led_i;
  logic [4:0]  div_i;
  logic        clr_i;
  logic [27:0] half_per_o;
  logic        per_vld_o;
  logic        match_o;
  logic        locked_o;
  logic        stuck_o;

  modport master (
    output led_i, div_i, clr_i,
    input  half_per_o, per_vld_o, match_o, locked_o, stuck_o
  );

  modport slave (
    input  led_i, div_i, clr_i,
    output half_per_o, per_vld_o, match_o, locked_o, stuck_o
  );
endinterface

// File: rtl/led_blink_mon_sync_edge.sv
// Multi-stage synchronizer for the asynchronous blink line plus a both-edge detector.
module led_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic edge_o,
  output logic lvl_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign lvl_o  = sync_q[SYNC_STAGES-1];
  assign edge_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/led_blink_mon.sv
// Blink-rate checker: measures toggle-to-toggle intervals on led_i and compares them
// against the half-period implied by div_i, reporting match, lock and stuck status.
module led_blink_mon
  import led_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [27:0] CNT_BASE    = CNT_1S,
  parameter logic [27:0] TIMEOUT     = 28'hBEBC200,
  parameter logic [27:0] TOL         = 28'd16,
  parameter logic [2:0]  LOCK_CNT    = 3'd2
) (
  input  logic            clk100,
  input  logic            rst_n,
  led_blink_mon_if.slave  mon
);

  localparam logic [27:0] TO_LAST = TIMEOUT - 28'd1;

  logic        led_edge;
  mon_state_t  state_q;
  logic [27:0] cnt_q, exp_q, half_per_q;
  logic [4:0]  div_q;
  logic [2:0]  mcnt_q;
  logic        per_vld_q, match_q, locked_q, stuck_q;

  led_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk100),
    .rst_n  (rst_n),
    .din    (mon.led_i),
    .edge_o (led_edge),
    .lvl_o  ()
  );

  // Expected interval per divisor, folded to constants at elaboration.
  logic [27:0] exp_tab [0:20];
  for (genvar g = 0; g <= 20; g++) begin : g_exp
    assign exp_tab[g] = cnt_max_f(CNT_BASE, 5'(g)) + 28'd1;
  end

  logic [4:0]  div_idx;
  logic [27:0] meas, diff, cnt_inc;
  logic [3:0]  mcnt_inc;
  logic        meas_ok, div_chg, lock_hit;

  always_comb begin
    div_idx  = (mon.div_i > DIV_MAX) ? 5'd0 : mon.div_i;
    meas     = cnt_q + 28'd1;
    diff     = (meas >= exp_q) ? (meas - exp_q) : (exp_q - meas);
    meas_ok  = (diff <= TOL);
    div_chg  = (mon.div_i != div_q);
    cnt_inc  = (cnt_q >= TIMEOUT) ? TIMEOUT : (cnt_q + 28'd1);
    mcnt_inc = {1'b0, mcnt_q} + 4'd1;
    lock_hit = (mcnt_inc >= {1'b0, LOCK_CNT});
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      exp_q      <= '0;
      div_q      <= '0;
      mcnt_q     <= '0;
      half_per_q <= '0;
      per_vld_q  <= 1'b0;
      match_q    <= 1'b0;
      locked_q   <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      div_q     <= mon.div_i;
      exp_q     <= exp_tab[div_idx];
      per_vld_q <= 1'b0;
      if (mon.clr_i) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        mcnt_q     <= '0;
        half_per_q <= '0;
        match_q    <= 1'b0;
        locked_q   <= 1'b0;
        stuck_q    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (led_edge) begin
              state_q <= ARMED;
              cnt_q   <= '0;
            end
          end
          ARMED, LOCKED: begin
            if (led_edge) begin
              cnt_q      <= '0;
              half_per_q <= meas;
              per_vld_q  <= 1'b1;
              match_q    <= meas_ok;
              // A divisor change in the same cycle voids the lock progress.
              if (meas_ok && !div_chg) begin
                mcnt_q <= lock_hit ? LOCK_CNT : mcnt_inc[2:0];
                if (lock_hit) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                end
              end else begin
                mcnt_q   <= '0;
                state_q  <= ARMED;
                locked_q <= 1'b0;
              end
            end else if (div_chg) begin
              cnt_q    <= cnt_inc;
              mcnt_q   <= '0;
              state_q  <= ARMED;
              locked_q <= 1'b0;
            end else if (cnt_q >= TO_LAST) begin
              cnt_q    <= cnt_inc;
              mcnt_q   <= '0;
              state_q  <= STUCK;
              stuck_q  <= 1'b1;
              locked_q <= 1'b0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          STUCK: begin
            // The overlong interval is discarded; measurement restarts from this edge.
            if (led_edge) begin
              state_q <= ARMED;
              stuck_q <= 1'b0;
              cnt_q   <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign mon.half_per_o = half_per_q;
  assign mon.per_vld_o  = per_vld_q;
  assign mon.match_o    = match_q;
  assign mon.locked_o   = locked_q;
  assign mon.stuck_o    = stuck_q;

endmodule

// File: tb/tb_led_blink_mon.sv
// Directed bench for led_blink_mon with shrunk timing (base 120, timeout 400, tol 2).
module tb_led_blink_mon;

  logic clk100 = 1'b0;
  logic rst_n  = 1'b0;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  int hp_q[$];
  int m_q[$];
  int lk_q[$];
  int pulse_cyc = 0;

  led_blink_mon_if mon_if();

  led_blink_mon #(
    .SYNC_STAGES (2),
    .CNT_BASE    (28'd120),
    .TIMEOUT     (28'd400),
    .TOL         (28'd2),
    .LOCK_CNT    (3'd2)
  ) dut (
    .clk100 (clk100),
    .rst_n  (rst_n),
    .mon    (mon_if)
  );

  always #5 clk100 = ~clk100;
  always @(posedge clk100) cyc <= cyc + 1;

  always @(negedge clk100) begin
    if (mon_if.per_vld_o) begin
      hp_q.push_back(int'(mon_if.half_per_o));
      m_q.push_back(int'(mon_if.match_o));
      lk_q.push_back(int'(mon_if.locked_o));
      pulse_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic run_toggles(input int period, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (period) tick();
      mon_if.led_i = ~mon_if.led_i;
    end
  endtask

  task automatic apply_clr();
    mon_if.clr_i = 1'b1;
    tick();
    mon_if.clr_i = 1'b0;
    tick();
    hp_q.delete(); m_q.delete(); lk_q.delete();
  endtask

  task automatic test_reset();
    n_chk++;
    if ({mon_if.half_per_o, mon_if.per_vld_o, mon_if.match_o, mon_if.locked_o, mon_if.stuck_o} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got hp=%0d vld=%b m=%b lk=%b st=%b, want all 0",
               mon_if.half_per_o, mon_if.per_vld_o, mon_if.match_o, mon_if.locked_o, mon_if.stuck_o);
    end
  endtask

  task automatic test_basic_lock();
    int exp_hp[3] = '{41, 41, 41};
    int exp_lk[3] = '{0, 1, 1};
    hp_q.delete(); m_q.delete(); lk_q.delete();
    run_toggles(41, 4);
    repeat (5) tick();
    n_chk++;
    if (hp_q.size() !== 3) begin
      n_fail++; $display("FAIL basic_pulse_count: got %0d want 3", hp_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      int hp = (i < hp_q.size()) ? hp_q[i] : -1;
      int m  = (i < m_q.size())  ? m_q[i]  : -1;
      int lk = (i < lk_q.size()) ? lk_q[i] : -1;
      n_chk++;
      if (hp !== exp_hp[i] || m !== 1 || lk !== exp_lk[i]) begin
        n_fail++;
        $display("FAIL basic_pulse%0d: got hp=%0d m=%0d lk=%0d want hp=%0d m=1 lk=%0d",
                 i, hp, m, lk, exp_hp[i], exp_lk[i]);
      end
    end
  endtask

  task automatic test_tolerance();
    int exp_hp[6] = '{44, 44, 43, 43, 43, 44};
    int exp_m[6]  = '{0, 0, 1, 1, 1, 0};
    int exp_lk[6] = '{0, 0, 0, 1, 1, 0};
    apply_clr();
    run_toggles(44, 3);
    run_toggles(43, 3);
    run_toggles(44, 1);
    repeat (5) tick();
    n_chk++;
    if (hp_q.size() !== 6) begin
      n_fail++; $display("FAIL tol_pulse_count: got %0d want 6", hp_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      int hp = (i < hp_q.size()) ? hp_q[i] : -1;
      int m  = (i < m_q.size())  ? m_q[i]  : -1;
      int lk = (i < lk_q.size()) ? lk_q[i] : -1;
      n_chk++;
      if (hp !== exp_hp[i] || m !== exp_m[i] || lk !== exp_lk[i]) begin
        n_fail++;
        $display("FAIL tol_pulse%0d: got hp=%0d m=%0d lk=%0d want hp=%0d m=%0d lk=%0d",
                 i, hp, m, lk, exp_hp[i], exp_m[i], exp_lk[i]);
      end
    end
  endtask

  task automatic test_stuck();
    int stuck_at = -1;
    int last_pulse;
    int exp_hp[3] = '{45, 41, 41};
    int exp_m[3]  = '{0, 1, 1};
    int exp_lk[3] = '{0, 0, 1};
    apply_clr();
    run_toggles(41, 3);
    for (int i = 0; i < 600 && stuck_at < 0; i++) begin
      tick();
      if (mon_if.stuck_o) stuck_at = cyc;
    end
    last_pulse = pulse_cyc;
    n_chk++;
    if (stuck_at < 0 || (stuck_at - last_pulse) !== 400) begin
      n_fail++;
      $display("FAIL stuck_delay: got %0d cycles (seen=%0d) want 400", stuck_at - last_pulse, stuck_at >= 0);
    end
    n_chk++;
    if (mon_if.locked_o !== 1'b0) begin
      n_fail++; $display("FAIL stuck_unlock: got locked=%b want 0", mon_if.locked_o);
    end
    hp_q.delete(); m_q.delete(); lk_q.delete();
    run_toggles(41, 1);
    repeat (4) tick();
    n_chk++;
    if (mon_if.stuck_o !== 1'b0 || hp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL stuck_release: got stuck=%b pulses=%0d want stuck=0 pulses=0", mon_if.stuck_o, hp_q.size());
    end
    run_toggles(41, 3);
    repeat (5) tick();
    for (int i = 0; i < 3; i++) begin
      int hp = (i < hp_q.size()) ? hp_q[i] : -1;
      int m  = (i < m_q.size())  ? m_q[i]  : -1;
      int lk = (i < lk_q.size()) ? lk_q[i] : -1;
      n_chk++;
      if (hp !== exp_hp[i] || m !== exp_m[i] || lk !== exp_lk[i]) begin
        n_fail++;
        $display("FAIL relock_pulse%0d: got hp=%0d m=%0d lk=%0d want hp=%0d m=%0d lk=%0d",
                 i, hp, m, lk, exp_hp[i], exp_m[i], exp_lk[i]);
      end
    end
  endtask

  task automatic test_div_change();
    logic [4:0] new_div[2] = '{5'd0, 5'd21};
    int exp_hp[4] = '{128, 121, 121, 121};
    int exp_m[4]  = '{0, 1, 1, 1};
    int exp_lk[4] = '{0, 0, 1, 1};
    apply_clr();
    run_toggles(41, 3);
    repeat (5) tick();
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (mon_if.locked_o !== 1'b1) begin
        n_fail++; $display("FAIL div%0d_prelock: got locked=%b want 1", new_div[k], mon_if.locked_o);
      end
      mon_if.div_i = new_div[k];
      repeat (2) tick();
      n_chk++;
      if (mon_if.locked_o !== 1'b0) begin
        n_fail++; $display("FAIL div%0d_unlock: got locked=%b want 0", new_div[k], mon_if.locked_o);
      end
      hp_q.delete(); m_q.delete(); lk_q.delete();
      run_toggles(121, 4);
      repeat (5) tick();
      for (int i = 0; i < 4; i++) begin
        int hp = (i < hp_q.size()) ? hp_q[i] : -1;
        int m  = (i < m_q.size())  ? m_q[i]  : -1;
        int lk = (i < lk_q.size()) ? lk_q[i] : -1;
        n_chk++;
        if (hp !== exp_hp[i] || m !== exp_m[i] || lk !== exp_lk[i]) begin
          n_fail++;
          $display("FAIL div%0d_pulse%0d: got hp=%0d m=%0d lk=%0d want hp=%0d m=%0d lk=%0d",
                   new_div[k], i, hp, m, lk, exp_hp[i], exp_m[i], exp_lk[i]);
        end
      end
    end
    mon_if.div_i = 5'd3;
    repeat (2) tick();
  endtask

  task automatic test_clr_on_edge();
    apply_clr();
    run_toggles(41, 3);
    repeat (5) tick();
    hp_q.delete(); m_q.delete(); lk_q.delete();
    mon_if.led_i = ~mon_if.led_i;
    repeat (2) tick();
    mon_if.clr_i = 1'b1;
    tick();
    mon_if.clr_i = 1'b0;
    tick();
    n_chk++;
    if (hp_q.size() !== 0 || mon_if.half_per_o !== 28'd0 || mon_if.match_o !== 1'b0 ||
        mon_if.locked_o !== 1'b0 || mon_if.stuck_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_edge: got pulses=%0d hp=%0d m=%b lk=%b st=%b want all 0",
               hp_q.size(), mon_if.half_per_o, mon_if.match_o, mon_if.locked_o, mon_if.stuck_o);
    end
    run_toggles(41, 3);
    repeat (5) tick();
    n_chk++;
    if (hp_q.size() !== 2 || (hp_q.size() == 2 && (hp_q[0] !== 41 || hp_q[1] !== 41 || lk_q[1] !== 1))) begin
      n_fail++;
      $display("FAIL clr_first_edge: got pulses=%0d locked=%b want 2 pulses of 41 and lock",
               hp_q.size(), mon_if.locked_o);
    end
  endtask

  task automatic test_async_reset();
    apply_clr();
    run_toggles(41, 3);
    repeat (10) tick();
    n_chk++;
    if (mon_if.locked_o !== 1'b1) begin
      n_fail++; $display("FAIL arst_prelock: got locked=%b want 1", mon_if.locked_o);
    end
    rst_n = 1'b0;
    mon_if.led_i = 1'b0;
    #2;
    n_chk++;
    if ({mon_if.half_per_o, mon_if.per_vld_o, mon_if.match_o, mon_if.locked_o, mon_if.stuck_o} !== 32'd0) begin
      n_fail++;
      $display("FAIL arst_clear: got hp=%0d m=%b lk=%b st=%b want all 0",
               mon_if.half_per_o, mon_if.match_o, mon_if.locked_o, mon_if.stuck_o);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    hp_q.delete(); m_q.delete(); lk_q.delete();
    run_toggles(41, 3);
    repeat (5) tick();
    n_chk++;
    if (hp_q.size() !== 2 || (hp_q.size() == 2 && (hp_q[0] !== 41 || m_q[0] !== 1 || lk_q[0] !== 0 || lk_q[1] !== 1))) begin
      n_fail++;
      $display("FAIL arst_relock: got pulses=%0d locked=%b want 2 pulses of 41 locking on the 2nd",
               hp_q.size(), mon_if.locked_o);
    end
  endtask

  initial begin
    mon_if.led_i = 1'b0;
    mon_if.div_i = 5'd3;
    mon_if.clr_i = 1'b0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic_lock();
    test_tolerance();
    test_stuck();
    test_div_change();
    test_clr_on_edge();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
